// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: shared ALU operation codes and helpers
// for the iterative multiply/divide unit.
package mult_div_unit_pkg;

    typedef logic [3:0] aluop_t;

    localparam aluop_t OPMULT = 4'b1000;
    localparam aluop_t OPDIV  = 4'b1001;
    localparam aluop_t OPMFHI = 4'b1010;
    localparam aluop_t OPMFLO = 4'b1011;

    function automatic logic [31:0] mag32(input logic [31:0] v);
        return v[31] ? 32'(-v) : v;
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit: signed 32x32 multiply and 32/32 divide,
// one bit per cycle, results in HI/LO.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iStart,
    input  logic [3:0]       iALUCtrl,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    output logic             oBusy,
    output logic             oDone,
    output logic             oDivZero,
    output logic [WIDTH-1:0] oHI,
    output logic [WIDTH-1:0] oLO
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

    localparam int ITERS = 32;

    state_t               state;
    state_t               state_nx;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     opnd;
    logic [5:0]           cnt;
    logic                 neg_a;
    logic                 neg_b;
    logic                 is_div;
    logic                 dz;
    logic                 done;
    logic [WIDTH-1:0]     hi;
    logic [WIDTH-1:0]     lo;

    logic                 op_ok;
    logic                 accept;
    logic                 b_zero;
    logic                 last;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_rem;
    logic [WIDTH:0]       div_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     rem;

    assign op_ok  = (iALUCtrl == OPMULT) || (iALUCtrl == OPDIV);
    assign accept = iStart && (state == S_IDLE) && op_ok;
    assign b_zero = (iB == '0);
    assign last   = (cnt == 6'(ITERS - 1));

    // Shift-add step: add multiplicand on LSB, shift right.
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};

    // Restoring step: shifted partial remainder is 33 bits wide.
    assign div_rem  = acc[2*WIDTH-1:WIDTH-1];
    assign div_diff = div_rem - {1'b0, opnd};
    assign div_ge   = !div_diff[WIDTH];

    assign prod = (neg_a ^ neg_b) ? -acc : acc;
    assign quo  = (neg_a ^ neg_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem  = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (iALUCtrl == OPDIV) begin
                        state_nx = b_zero ? S_FIX : S_DIV;
                    end else begin
                        state_nx = S_MUL;
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (last) begin
                    state_nx = S_FIX;
                end
            end
            S_FIX: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            acc    <= '0;
            opnd   <= '0;
            cnt    <= '0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            is_div <= 1'b0;
            dz     <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= (state == S_FIX);
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        is_div <= (iALUCtrl == OPDIV);
                        neg_a  <= iA[WIDTH-1];
                        neg_b  <= iB[WIDTH-1];
                        cnt    <= '0;
                        dz     <= (iALUCtrl == OPDIV) && b_zero;
                        if (iALUCtrl == OPDIV) begin
                            acc  <= {{WIDTH{1'b0}}, mag32(iA)};
                            opnd <= b_zero ? iA : mag32(iB);
                        end else begin
                            acc  <= {{WIDTH{1'b0}}, mag32(iB)};
                            opnd <= mag32(iA);
                        end
                    end
                end
                S_MUL: begin
                    cnt <= cnt + 6'd1;
                    if (acc[0]) begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end else begin
                        acc <= {1'b0, acc[2*WIDTH-1:1]};
                    end
                end
                S_DIV: begin
                    cnt <= cnt + 6'd1;
                    if (div_ge) begin
                        acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                    end else begin
                        acc <= {acc[2*WIDTH-2:0], 1'b0};
                    end
                end
                S_FIX: begin
                    // Zero divisor keeps the dividend raw in opnd.
                    if (dz) begin
                        hi <= opnd;
                        lo <= '1;
                    end else if (is_div) begin
                        hi <= rem;
                        lo <= quo;
                    end else begin
                        hi <= prod[2*WIDTH-1:WIDTH];
                        lo <= prod[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign oBusy    = (state != S_IDLE);
    assign oDone    = done;
    assign oDivZero = dz;
    assign oHI      = hi;
    assign oLO      = lo;

endmodule
